mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter that shares one pipelined carry-save multiplier (WIDTH x WIDTH, MUL_LAT register stages, no handshake of its own) between NREQ requesters. It accepts operand pairs over a valid/ready interface and issues at most one operation per cycle to the multiplier. It tracks each in-flight operation's owner in a tag pipeline and routes each product back to its owner as a one-cycle response pulse. It sits between client blocks and the multiplier instance; the multiplier itself is external.

## Interface
- WIDTH, 4, operand width; product width is 2*WIDTH
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 2, multiplier register stages (input reg + output reg); mul_y is sampled MUL_LAT+1 edges after mul_a/mul_b update
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand b, same packing
- mul_a  out  WIDTH  operand a to multiplier, registered
- mul_b  out  WIDTH  operand b to multiplier, registered
- mul_y  in  2*WIDTH  product from multiplier
- resp_valid  out  NREQ  one-hot response strobe, registered
- resp_y  out  2*WIDTH  product for the strobed requester, registered

## Operation
- Per-requester state busy[i]: IDLE (0) or BUSY (1). Each requester has at most one operation in flight.
- Eligible set: i with req_valid[i] & ~busy[i]. Winner: first eligible index searching ptr, ptr+1, ... mod NREQ.
- req_ready[winner] = 1, all others 0 (combinational from req_valid, busy, ptr). Requesters must not derive req_valid from req_ready.
- Accept = req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - mul_a/mul_b load req_a/req_b slice i.
  - busy[i] goes to 1.
  - ptr goes to (i+1) mod NREQ.
  - Tag pipeline stage 0 loads {valid=1, id=i}.
- No accept in a cycle: mul_a/mul_b hold their value, ptr holds, and tag stage 0 loads valid=0.
- Tag pipeline is MUL_LAT+1 stages deep and shifts every cycle.
- When the last stage holds valid=1, id=k, the next edge sets resp_valid = one-hot(k), resp_y = mul_y, and clears busy[k]. Otherwise resp_valid = 0 and resp_y holds.
- Responses have no backpressure; clients must take the strobe.
- Product is unsigned: resp_y = a*b mod 2^(2*WIDTH), exact for all operands.

## Timing
- Reset (async assert, any time): req_ready=0 while rst high; mul_a=0, mul_b=0, resp_valid=0, resp_y=0, busy=0, ptr=0, all tag stages invalid. In-flight operations are dropped and never produce a response.
- Latency: accept at edge t → resp_valid high during the cycle after edge t+MUL_LAT+1. Default: 3 cycles.
- Throughput: one accept per cycle across requesters; per requester, one per MUL_LAT+2 cycles at best.
- Same requester: busy[k] clears on the response edge. req_ready[k] can assert in the same cycle resp_valid[k] is high, so a re-issue lands on the edge ending the response cycle.
- Simultaneous events:
  - Response for k and accept for j≠k on the same edge are independent.
  - Concurrent requests from all NREQ are granted in rotating order from ptr, one per cycle.
- Response order equals issue order.
- A requester dropping req_valid before acceptance withdraws cleanly; no state changes.

## Test plan
- Single op: after reset, requester 0 presents a=3, b=5 → req_ready[0]=1 same cycle; 3 cycles later resp_valid=0001, resp_y=15 for exactly one cycle.
- Full contention: all 4 valid at once with (a,b)=(1,2),(2,3),(3,4),(15,15) → accepts on 4 consecutive edges in order 0,1,2,3; responses on 4 consecutive cycles: 2, 6, 12, 225.
- Round-robin fairness: requesters 1 and 2 hold valid continuously → grants alternate 1,2,1,2; each gets 1 grant per MUL_LAT+2 cycles (per-requester BUSY limit), none starved.
- Busy blocking: requester 0 holds valid with a new op right after accept → req_ready[0]=0 until resp cycle, then accept; second result correct.
- Reset mid-flight: accept 2 ops, assert rst one cycle later → all outputs 0 immediately, no resp_valid after release, next op after reset returns correct product.
- Exhaustive operands: requester 3 sweeps all 256 (a,b) pairs back-to-back → every resp_y equals a*b, no missing or duplicate strobes.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin front end that shares one external pipelined
//            multiplier among NREQ requesters. It accepts at most one operand
//            pair per cycle, remembers the owner of each in-flight operation
//            in a tag pipeline matched to the multiplier latency, and returns
//            each product to its owner as a one-cycle strobe.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            req_valid/ready  - per-requester request handshake (ready is
//                               one-hot or zero)
//            req_a/req_b      - packed operands, requester i at [i*WIDTH +: WIDTH]
//            mul_a/mul_b      - registered operands to the multiplier
//            mul_y            - product from the multiplier
//            resp_valid/y     - registered one-hot response strobe and product
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    output logic [NREQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]      resp_y
);

    // Pointer / id width, one extra bit for the wrap-around arithmetic, and
    // tag pipeline depth (one stage per multiplier register plus the stage
    // that lines up with the cycle the product is sampled).
    localparam int c_PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_IW    = c_PW + 1;
    localparam int c_DEPTH = MUL_LAT + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NREQ-1:0]     r_busy;
    logic [c_PW-1:0]     r_ptr;
    logic [WIDTH-1:0]    r_mul_a;
    logic [WIDTH-1:0]    r_mul_b;
    logic [NREQ-1:0]     r_resp_valid;
    logic [2*WIDTH-1:0]  r_resp_y;
    logic                r_tag_v  [c_DEPTH];
    logic [c_PW-1:0]     r_tag_id [c_DEPTH];

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [NREQ-1:0]     w_elig;
    logic                w_found;
    logic [c_PW-1:0]     w_win;
    logic [c_IW-1:0]     w_idx;
    logic [NREQ-1:0]     w_grant;
    logic                w_accept;
    logic [c_PW-1:0]     w_ptr_nxt;

    assign w_elig = req_valid & ~r_busy;

    // Scan ptr, ptr+1, ... modulo NREQ; the first eligible index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_idx = {1'b0, r_ptr} + c_IW'(j);
            if (w_idx >= c_IW'(NREQ)) begin
                w_idx = w_idx - c_IW'(NREQ);
            end
            if (!w_found && w_elig[w_idx[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PW-1:0];
            end
        end
    end

    // Ready is held low for as long as reset is asserted, even though the
    // busy bits are already clear, so nothing is accepted into a pipeline
    // that is being flushed.
    assign w_grant   = (w_found && !rst) ? (NREQ'(1) << w_win) : '0;
    assign req_ready = w_grant;
    assign w_accept  = |(req_valid & w_grant);
    assign w_ptr_nxt = (w_win == c_PW'(NREQ - 1)) ? '0 : (w_win + 1'b1);

    // ------------------------------------------------------------------------
    // Response / busy bookkeeping
    // ------------------------------------------------------------------------
    logic                w_resp_fire;
    logic [c_PW-1:0]     w_resp_id;
    logic [NREQ-1:0]     w_busy_clr;
    logic [NREQ-1:0]     w_busy_set;
    logic [NREQ-1:0]     w_busy_nxt;

    assign w_resp_fire = r_tag_v[c_DEPTH-1];
    assign w_resp_id   = r_tag_id[c_DEPTH-1];
    assign w_busy_clr  = w_resp_fire ? (NREQ'(1) << w_resp_id) : '0;
    assign w_busy_set  = req_valid & w_grant;

    // A requester can only be granted while idle, so set and clear never
    // target the same bit on one edge.
    assign w_busy_nxt  = (r_busy & ~w_busy_clr) | w_busy_set;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_ptr        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_resp_valid <= '0;
            r_resp_y     <= '0;
            for (int s = 0; s < c_DEPTH; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_mul_a <= req_a[w_win*WIDTH +: WIDTH];
                r_mul_b <= req_b[w_win*WIDTH +: WIDTH];
                r_ptr   <= w_ptr_nxt;
            end

            // Owner tag travels alongside the operation through the
            // multiplier so the product can be routed back.
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_win;
            for (int s = 1; s < c_DEPTH; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end

            r_resp_valid <= '0;
            if (w_resp_fire) begin
                r_resp_valid <= NREQ'(1) << w_resp_id;
                r_resp_y     <= mul_y;
            end

            r_busy <= w_busy_nxt;
        end
    end

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;

    // ------------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_resp_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(resp_valid));

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Purpose  : Self-checking bench for mult_share_arbiter. Includes a behavioural
//            model of the external multiplier, a reference arbiter model and
//            a scoreboard of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W2  = 2 * W;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W2-1:0]     mul_y;
    logic [N-1:0]      resp_valid;
    logic [W2-1:0]     resp_y;

    mult_share_arbiter #(.WIDTH(W), .NREQ(N), .MUL_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_y      (mul_y),
        .resp_valid (resp_valid),
        .resp_y     (resp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier model: LAT register stages, no reset.
    logic [W2-1:0] ms [LAT];
    initial for (int i = 0; i < LAT; i++) ms[i] = '0;
    always @(posedge clk) begin
        ms[0] <= W2'(mul_a) * W2'(mul_b);
        for (int i = 1; i < LAT; i++) ms[i] <= ms[i-1];
    end
    assign mul_y = ms[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------------
    typedef struct { int id; int prod; int due; } exp_t;
    typedef struct { int id; int cyc; } grant_t;

    exp_t    sb[$];
    grant_t  glog[$];
    int      rlog[$];
    int      resp_cnt [N];

    logic [N-1:0] m_busy;
    int           m_ptr;
    int           m_y;
    int           m_a;
    int           m_b;
    logic [N-1:0] m_ready;
    int           m_win;
    int           m_k;
    logic         m_found;
    logic [N-1:0] acc;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_busy = '0; m_ptr = 0; m_y = 0; m_a = 0; m_b = 0;
            check("rst_ready", req_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_resp_y", resp_y, 0);
            check("rst_mul_a", mul_a, 0);
        end else begin
            // Response for this cycle (busy clears on the response edge).
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("resp_valid", resp_valid, N'(1) << e.id);
                check("resp_y", resp_y, e.prod);
                m_y = e.prod;
                m_busy[e.id] = 1'b0;
            end else begin
                check("resp_idle", resp_valid, 0);
                check("resp_y_hold", resp_y, m_y);
            end
            for (int i = 0; i < N; i++) if (resp_valid[i]) resp_cnt[i]++;
            if (resp_valid != 0) rlog.push_back(int'(resp_y));

            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);

            // Expected grant from the rotating priority.
            m_found = 1'b0; m_win = 0; m_ready = '0;
            for (int j = 0; j < N; j++) begin
                m_k = (m_ptr + j) % N;
                if (!m_found && req_valid[m_k] && !m_busy[m_k]) begin
                    m_found = 1'b1;
                    m_win = m_k;
                end
            end
            if (m_found) m_ready[m_win] = 1'b1;
            check("req_ready", req_ready, m_ready);

            acc = req_valid & req_ready;
            for (int i = 0; i < N; i++) if (acc[i]) glog.push_back('{id: i, cyc: cyc});

            if (m_found) begin
                m_a = int'(req_a[m_win*W +: W]);
                m_b = int'(req_b[m_win*W +: W]);
                sb.push_back('{id: m_win, prod: m_a * m_b, due: cyc + LAT + 2});
                m_busy[m_win] = 1'b1;
                m_ptr = (m_win + 1) % N;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one operation and hold it until accepted.
    task automatic issue(input int id, input int a, input int b);
        int n;
        n = 0;
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        req_valid[id] = 1'b1;
        @(negedge clk);
        while (!req_ready[id] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[id]) check("issue_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        @(posedge clk); #1;
        check("drain", sb.size(), 0);
    endtask

    task automatic clear_logs();
        glog.delete();
        rlog.delete();
        for (int i = 0; i < N; i++) resp_cnt[i] = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        clear_logs();
        apply_reset();

        // Single op with exact latency.
        @(posedge clk); #1;
        req_a[3:0] = 4'd3; req_b[3:0] = 4'd5; req_valid[0] = 1'b1;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("t1_early", resp_valid, 0);
        @(posedge clk);
        #1 check("t1_resp_v", resp_valid, 4'b0001);
        check("t1_resp_y", resp_y, 15);
        @(posedge clk);
        #1 check("t1_pulse", resp_valid, 0);
        drain();

        // Full contention.
        apply_reset();
        clear_logs();
        fork
            issue(0, 1, 2);
            issue(1, 2, 3);
            issue(2, 3, 4);
            issue(3, 15, 15);
        join
        drain();
        check("t2_grants", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            check("t2_order", glog[i].id, i);
            check("t2_consec", glog[i].cyc - glog[0].cyc, i);
        end
        check("t2_nresp", rlog.size(), 4);
        if (rlog.size() == 4) begin
            check("t2_y0", rlog[0], 2);
            check("t2_y1", rlog[1], 6);
            check("t2_y2", rlog[2], 12);
            check("t2_y3", rlog[3], 225);
        end

        // Fairness between two continuously-valid requesters.
        apply_reset();
        clear_logs();
        fork
            begin for (int i = 0; i < 4; i++) issue(1, i + 1, 3); end
            begin for (int i = 0; i < 4; i++) issue(2, i + 2, 7); end
        join
        drain();
        check("t3_grants", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            check("t3_alt", glog[i].id, (i % 2 == 0) ? 1 : 2);
            if (i >= 2) check("t3_gap", glog[i].cyc - glog[i-2].cyc, LAT + 2);
        end

        // Busy blocking for the same requester.
        apply_reset();
        clear_logs();
        issue(0, 6, 7);
        issue(0, 9, 9);
        drain();
        check("t4_grants", glog.size(), 2);
        if (glog.size() == 2) check("t4_gap", glog[1].cyc - glog[0].cyc, LAT + 2);
        check("t4_nresp", rlog.size(), 2);
        if (rlog.size() == 2) begin
            check("t4_y0", rlog[0], 42);
            check("t4_y1", rlog[1], 81);
        end

        // Reset with operations in flight.
        apply_reset();
        clear_logs();
        fork
            issue(0, 5, 6);
            issue(1, 7, 8);
        join
        #2 rst = 1'b1;
        req_a[15:12] = 4'd2; req_b[15:12] = 4'd2; req_valid[3] = 1'b1;
        #1;
        check("t5_ready", req_ready, 0);
        check("t5_mul_a", mul_a, 0);
        check("t5_mul_b", mul_b, 0);
        check("t5_resp_v", resp_valid, 0);
        check("t5_resp_y", resp_y, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; req_valid = '0;
        repeat (6) @(posedge clk);
        #1 check("t5_no_resp", rlog.size(), 0);
        issue(2, 7, 9);
        drain();
        check("t5_nresp", rlog.size(), 1);
        if (rlog.size() == 1) check("t5_y", rlog[0], 63);

        // Exhaustive operand sweep on requester 3.
        apply_reset();
        clear_logs();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                issue(3, a, b);
        drain();
        check("t6_count", resp_cnt[3], 256);
        check("t6_other", resp_cnt[0] + resp_cnt[1] + resp_cnt[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
